// File: rtl/mod_step_counter_pkg.sv
// mod_step_counter_pkg: boundary-mode encoding shared by the step counter files.
// Ports: none (package).
package mod_step_counter_pkg;
  typedef logic [1:0] mode_t;
  localparam mode_t MODE_WRAP_ZERO = 2'd0;
  localparam mode_t MODE_MODULO    = 2'd1;
  localparam mode_t MODE_SATURATE  = 2'd2;
endpackage

// File: rtl/mod_step_counter_if.sv
// mod_step_counter_if: control and status bundle of the modulo step counter.
// master drives en/clr/dir/mode/step/limit and observes count/display/at_limit/tc/events;
// slave is the counter side.
interface mod_step_counter_if
  import mod_step_counter_pkg::*;
#(
  parameter int WIDTH  = 7,
  parameter int DISP_W = 4,
  parameter int EVT_W  = 8
) ();
  logic              en;
  logic              clr;
  logic              dir;
  mode_t             mode;
  logic [WIDTH-1:0]  step;
  logic [WIDTH-1:0]  limit;
  logic [WIDTH-1:0]  count;
  logic [DISP_W-1:0] display;
  logic              at_limit;
  logic              tc;
  logic [EVT_W-1:0]  events;
  modport master (
    output en, clr, dir, mode, step, limit,
    input  count, display, at_limit, tc, events
  );
  modport slave (
    input  en, clr, dir, mode, step, limit,
    output count, display, at_limit, tc, events
  );
endinterface

// File: rtl/mod_step_counter_next.sv
// mod_step_counter_next: combinational next-count and boundary-event computation.
// Ports: count_i/step_i/limit_i (WIDTH), dir_i, mode_i in; next_o (WIDTH), bnd_o out.
module mod_step_counter_next
  import mod_step_counter_pkg::*;
#(
  parameter int WIDTH = 7
) (
  input  logic [WIDTH-1:0] count_i,
  input  logic [WIDTH-1:0] step_i,
  input  logic [WIDTH-1:0] limit_i,
  input  logic             dir_i,
  input  mode_t            mode_i,
  output logic [WIDTH-1:0] next_o,
  output logic             bnd_o
);
  // Two guard bits: one for the carry of count+step, one as sign of the down-modulo result.
  localparam int XW = WIDTH + 2;
  logic [XW-1:0]    c, s, l, up_sum, ov_mod, dn_mod;
  logic             over, up_ovf, dn_unf, hi;
  logic [WIDTH-1:0] mod_res, plain;
  always_comb begin
    c      = XW'(count_i);
    s      = XW'(step_i);
    l      = XW'(limit_i);
    up_sum = c + s;
    // A count already above a lowered limit is an overflow regardless of direction.
    over   = c > l;
    up_ovf = ~dir_i & (up_sum > l);
    dn_unf = dir_i & (c < s);
    hi     = over | up_ovf;
    ov_mod = (over ? c : up_sum) - l - XW'(1);
    dn_mod = c + l + XW'(1) - s;
    // Single reduction, then clamp into [0, limit] when step exceeds the modulus.
    mod_res = hi ? (ov_mod > l ? limit_i : ov_mod[WIDTH-1:0])
                 : (dn_mod[XW-1] ? '0 : (dn_mod > l ? limit_i : dn_mod[WIDTH-1:0]));
    plain  = dir_i ? count_i - step_i : count_i + step_i;
    bnd_o  = hi | dn_unf;
    next_o = !bnd_o                    ? plain
           : mode_i == MODE_MODULO    ? mod_res
           : mode_i == MODE_SATURATE  ? (hi ? limit_i : '0)
           :                            (hi ? '0 : limit_i);
  end
endmodule

// File: rtl/mod_step_counter.sv
// mod_step_counter: modulo step counter with wrap/modulo/saturate boundary modes.
// Ports: clk, reset (async, active-high), bus (mod_step_counter_if.slave): en, clr, dir,
// mode, step, limit in; count, display, at_limit, tc, events out.
module mod_step_counter
  import mod_step_counter_pkg::*;
#(
  parameter int WIDTH  = 7,
  parameter int DISP_W = 4,
  parameter int EVT_W  = 8
) (
  input logic               clk,
  input logic               reset,
  mod_step_counter_if.slave bus
);
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d, bnd;
  logic [EVT_W-1:0] events_q, events_d;
  mod_step_counter_next #(.WIDTH(WIDTH)) u_next (
    .count_i (count_q),
    .step_i  (bus.step),
    .limit_i (bus.limit),
    .dir_i   (bus.dir),
    .mode_i  (bus.mode),
    .next_o  (count_d),
    .bnd_o   (bnd)
  );
  // Saturate pulses only on entry into the clamp value, never while parked on it.
  always_comb begin
    tc_d = bus.mode == MODE_SATURATE
         ? (count_d != count_q) &&
           (count_d == ((count_q > bus.limit || !bus.dir) ? bus.limit : '0))
         : bnd;
    events_d = events_q + EVT_W'(tc_d && events_q != '1);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q  <= '0;
      tc_q     <= 1'b0;
      events_q <= '0;
    end else if (bus.clr) begin
      count_q  <= '0;
      tc_q     <= 1'b0;
      events_q <= '0;
    end else if (bus.en) begin
      count_q  <= count_d;
      tc_q     <= tc_d;
      events_q <= events_d;
    end else begin
      tc_q     <= 1'b0;
    end
  end
  assign bus.count    = count_q;
  assign bus.tc       = tc_q;
  assign bus.events   = events_q;
  assign bus.at_limit = count_q == bus.limit;
  assign bus.display  = bus.at_limit ? '0 : count_q[DISP_W-1:0];
endmodule

// File: tb/tb_mod_step_counter.sv
// tb_mod_step_counter: directed and random checks of mod_step_counter against an integer model.
module tb_mod_step_counter;
  import mod_step_counter_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  int m_count = 0;
  int m_tc = 0;
  int m_events = 0;
  mod_step_counter_if #(.WIDTH(7), .DISP_W(4), .EVT_W(8)) bus ();
  mod_step_counter #(.WIDTH(7), .DISP_W(4), .EVT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic set(input bit en, input bit clr, input bit dir, input int mode,
                     input int step, input int limit);
    bus.en    = en;
    bus.clr   = clr;
    bus.dir   = dir;
    bus.mode  = mode_t'(mode);
    bus.step  = 7'(step);
    bus.limit = 7'(limit);
  endtask
  // Integer reference of one clock edge, from the counting rules.
  function automatic void model_edge();
    int c, lim, st, md, n;
    bit b, hi;
    c = m_count;
    lim = int'(bus.limit);
    st = int'(bus.step);
    md = int'(bus.mode);
    b = 0;
    hi = 0;
    if (bus.clr) begin
      m_count = 0;
      m_tc = 0;
      m_events = 0;
      return;
    end
    if (!bus.en) begin
      m_tc = 0;
      return;
    end
    if (c > lim || (!bus.dir && c + st > lim)) begin
      b = 1;
      hi = 1;
      n = md == 1 ? (c > lim ? c : c + st) - (lim + 1) : md == 2 ? lim : 0;
    end else if (bus.dir && c < st) begin
      b = 1;
      n = md == 1 ? c + lim + 1 - st : md == 2 ? 0 : lim;
    end else begin
      n = bus.dir ? c - st : c + st;
    end
    if (n > lim) n = lim;
    if (n < 0) n = 0;
    if (md == 2) m_tc = int'(n != c && ((hi || !bus.dir) ? n == lim : n == 0));
    else m_tc = int'(b);
    m_count = n;
    if (m_tc == 1 && m_events < 255) m_events++;
  endfunction
  task automatic cyc(input int exp_c = -1);
    model_edge();
    @(posedge clk);
    #1;
    chk("count", int'(bus.count), m_count);
    chk("tc", int'(bus.tc), m_tc);
    chk("events", int'(bus.events), m_events);
    chk("display", int'(bus.display), m_count == int'(bus.limit) ? 0 : m_count % 16);
    chk("at_limit", int'(bus.at_limit), int'(m_count == int'(bus.limit)));
    if (exp_c >= 0) chk("seq", int'(bus.count), exp_c);
  endtask
  initial begin
    int wz[5] = '{3, 6, 9, 0, 3};
    int md[7] = '{3, 6, 9, 2, 5, 8, 1};
    int su[5] = '{4, 8, 9, 9, 9};
    int sd[4] = '{5, 1, 0, 0};
    int dw[5] = '{6, 4, 2, 0, 6};
    set(0, 0, 0, 0, 0, 0);
    #12;
    chk("rst_count", int'(bus.count), 0);
    chk("rst_tc", int'(bus.tc), 0);
    chk("rst_events", int'(bus.events), 0);
    reset = 1'b0;
    set(1, 0, 0, 0, 3, 9);
    foreach (wz[i]) cyc(wz[i]);
    set(0, 1, 0, 0, 3, 9);
    cyc(0);
    set(1, 0, 0, 1, 3, 9);
    foreach (md[i]) cyc(md[i]);
    chk("mod_events", int'(bus.events), 2);
    set(0, 1, 0, 2, 4, 9);
    cyc(0);
    set(1, 0, 0, 2, 4, 9);
    foreach (su[i]) cyc(su[i]);
    set(1, 0, 1, 2, 4, 9);
    foreach (sd[i]) cyc(sd[i]);
    chk("sat_events", int'(bus.events), 2);
    set(0, 1, 1, 0, 2, 6);
    cyc(0);
    set(1, 0, 1, 0, 2, 6);
    foreach (dw[i]) cyc(dw[i]);
    set(0, 1, 0, 0, 1, 6);
    cyc(0);
    set(1, 0, 0, 0, 1, 6);
    cyc(1);
    set(1, 0, 1, 1, 2, 6);
    cyc(6);
    chk("mod_dn_tc", int'(bus.tc), 1);
    for (int m = 1; m >= 0; m--) begin
      set(0, 1, 0, m, 1, 9);
      cyc(0);
      set(1, 0, 0, m, 1, 9);
      repeat (8) cyc();
      set(1, 0, 0, m, 1, 5);
      cyc(m == 1 ? 2 : 0);
      chk("lower_tc", int'(bus.tc), 1);
    end
    set(1, 0, 0, 0, 3, 9);
    repeat (5) cyc();
    set(1, 1, 0, 0, 3, 9);
    cyc(0);
    set(1, 0, 0, 0, 4, 9);
    repeat (3) cyc();
    #2 reset = 1'b1;
    #1;
    chk("async_count", int'(bus.count), 0);
    chk("async_tc", int'(bus.tc), 0);
    chk("async_events", int'(bus.events), 0);
    m_count = 0;
    m_tc = 0;
    m_events = 0;
    #1 reset = 1'b0;
    set(1, 0, 0, 1, 1, 0);
    repeat (260) cyc();
    chk("evt_sat", int'(bus.events), 255);
    set(0, 1, 0, 0, 0, 0);
    cyc(0);
    for (int k = 0; k < 3000; k++) begin
      bus.en   = $urandom_range(0, 99) < 85;
      bus.clr  = $urandom_range(0, 99) < 2;
      bus.dir  = 1'($urandom);
      bus.mode = mode_t'($urandom);
      bus.step = $urandom_range(0, 1) == 1 ? 7'($urandom_range(0, 15)) : 7'($urandom);
      if ($urandom_range(0, 9) == 0) bus.limit = 7'($urandom);
      cyc();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
